// File: rtl/mac_vec_pipe_if.sv
// Stream interface for mac_vec_pipe: operand beats in, packed per-lane dot products out.
// master = producer/consumer side (testbench or upstream), slave = the MAC engine.
interface mac_vec_pipe_if #(
  parameter int DATA_WIDTH = 8,
  parameter int LANES      = 4,
  parameter int ACC_WIDTH  = DATA_WIDTH*3
);
  logic                        in_valid;
  logic                        in_ready;
  logic                        Signed;
  logic [LANES*DATA_WIDTH-1:0] Ain;
  logic [LANES*DATA_WIDTH-1:0] Bin;
  logic [LANES*ACC_WIDTH-1:0]  Cout;
  logic                        out_valid;
  logic                        out_ready;
  logic                        Ovf;

  modport master (
    output in_valid, Signed, Ain, Bin, out_ready,
    input  in_ready, Cout, out_valid, Ovf
  );

  modport slave (
    input  in_valid, Signed, Ain, Bin, out_ready,
    output in_ready, Cout, out_valid, Ovf
  );
endinterface

// File: rtl/mac_vec_pipe.sv
// LANES-wide pipelined multiply-accumulate: VEC_LEN beats per dot product, result held until handshake.
// Optional macro MAC_SAT_EN: saturating per-lane accumulation with sticky Ovf (default: modulo wrap, Ovf=0).
module mac_vec_pipe #(
  parameter int DATA_WIDTH = 8,
  parameter int LANES      = 4,
  parameter int ACC_WIDTH  = DATA_WIDTH*3,
  parameter int VEC_LEN    = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          Clr,
  mac_vec_pipe_if.slave bus
);

  localparam int PW = 2*DATA_WIDTH;
  localparam int CW = $clog2(VEC_LEN);

  typedef enum logic [1:0] {ACCUM = 2'd0, FLUSH = 2'd1, HOLD = 2'd2} state_t;

  function automatic logic [PW-1:0] lane_mul(input logic [DATA_WIDTH-1:0] a,
                                             input logic [DATA_WIDTH-1:0] b,
                                             input logic sgn);
    logic signed [PW-1:0] sa;
    logic signed [PW-1:0] sb;
    sa = PW'($signed(a));
    sb = PW'($signed(b));
    if (sgn) return sa * sb;
    else     return PW'(a) * PW'(b);
  endfunction

  function automatic logic [ACC_WIDTH-1:0] lane_ext(input logic [PW-1:0] p, input logic sgn);
    if (sgn) return ACC_WIDTH'($signed(p));
    else     return ACC_WIDTH'(p);
  endfunction

`ifdef MAC_SAT_EN
  localparam logic [ACC_WIDTH-1:0] SMAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic [ACC_WIDTH-1:0] SMIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  // Returns {clamped, sum}; signed overflow is detected on the extra sign bit.
  function automatic logic [ACC_WIDTH:0] lane_add(input logic [ACC_WIDTH-1:0] acc,
                                                  input logic [ACC_WIDTH-1:0] ext,
                                                  input logic sgn);
    logic [ACC_WIDTH:0] wide;
    if (sgn) begin
      wide = {acc[ACC_WIDTH-1], acc} + {ext[ACC_WIDTH-1], ext};
      if (wide[ACC_WIDTH] != wide[ACC_WIDTH-1])
        return {1'b1, (wide[ACC_WIDTH] ? SMIN : SMAX)};
    end else begin
      wide = {1'b0, acc} + {1'b0, ext};
      if (wide[ACC_WIDTH])
        return {1'b1, {ACC_WIDTH{1'b1}}};
    end
    return {1'b0, wide[ACC_WIDTH-1:0]};
  endfunction
`endif

  state_t                    state;
  logic [CW-1:0]             cnt_p0;
  logic                      accept_p0;
  logic [PW-1:0]             prod_p1 [LANES];
  logic                      sgn_p1;
  logic                      vld_p1;
  logic                      last_p1;
  logic [ACC_WIDTH-1:0]      acc_p2  [LANES];
  logic [ACC_WIDTH-1:0]      sum_p2  [LANES];
  logic [LANES*ACC_WIDTH-1:0] cout_p2;
  logic                      oval_p2;
  logic                      cnt_last_p0;
  logic                      handshake;

  assign bus.in_ready = (state == ACCUM) && !Clr;
  assign accept_p0    = bus.in_valid && bus.in_ready;
  assign cnt_last_p0  = (cnt_p0 == CW'(VEC_LEN-1));
  assign handshake    = (state == HOLD) && oval_p2 && bus.out_ready;

`ifdef MAC_SAT_EN
  logic [LANES-1:0] clamp_p2;
  logic             ovf_p2;

  always_comb begin
    clamp_p2 = '0;
    for (int i = 0; i < LANES; i++)
      {clamp_p2[i], sum_p2[i]} = lane_add(acc_p2[i], lane_ext(prod_p1[i], sgn_p1), sgn_p1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                ovf_p2 <= 1'b0;
    else if (Clr || handshake) ovf_p2 <= 1'b0;
    else if (vld_p1)           ovf_p2 <= ovf_p2 | (|clamp_p2);
  end

  assign bus.Ovf = ovf_p2;
`else
  always_comb begin
    for (int i = 0; i < LANES; i++)
      sum_p2[i] = acc_p2[i] + lane_ext(prod_p1[i], sgn_p1);
  end

  assign bus.Ovf = 1'b0;
`endif

  // Control: beat counter, stage valids, output valid and FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ACCUM;
      cnt_p0  <= '0;
      vld_p1  <= 1'b0;
      last_p1 <= 1'b0;
      oval_p2 <= 1'b0;
    end else if (Clr) begin
      state   <= ACCUM;
      cnt_p0  <= '0;
      vld_p1  <= 1'b0;
      last_p1 <= 1'b0;
      oval_p2 <= 1'b0;
    end else begin
      vld_p1 <= accept_p0;
      if (accept_p0) begin
        last_p1 <= cnt_last_p0;
        cnt_p0  <= cnt_last_p0 ? '0 : cnt_p0 + 1'b1;
      end
      if (vld_p1 && last_p1) oval_p2 <= 1'b1;
      case (state)
        ACCUM:   if (accept_p0 && cnt_last_p0) state <= FLUSH;
        FLUSH:   state <= HOLD;
        HOLD:    if (handshake) begin
                   state   <= ACCUM;
                   oval_p2 <= 1'b0;
                 end
        default: state <= ACCUM;
      endcase
    end
  end

  // Stage 1 -> stage 2: lane products, then accumulate / retire
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sgn_p1  <= 1'b0;
      cout_p2 <= '0;
      for (int i = 0; i < LANES; i++) begin
        prod_p1[i] <= '0;
        acc_p2[i]  <= '0;
      end
    end else if (Clr) begin
      cout_p2 <= '0;
      for (int i = 0; i < LANES; i++) acc_p2[i] <= '0;
    end else begin
      if (accept_p0) begin
        sgn_p1 <= bus.Signed;
        for (int i = 0; i < LANES; i++)
          prod_p1[i] <= lane_mul(bus.Ain[i*DATA_WIDTH +: DATA_WIDTH],
                                 bus.Bin[i*DATA_WIDTH +: DATA_WIDTH], bus.Signed);
      end
      if (vld_p1) begin
        for (int i = 0; i < LANES; i++) begin
          if (last_p1) begin
            cout_p2[i*ACC_WIDTH +: ACC_WIDTH] <= sum_p2[i];
            acc_p2[i] <= '0;
          end else begin
            acc_p2[i] <= sum_p2[i];
          end
        end
      end
    end
  end

  assign bus.Cout      = cout_p2;
  assign bus.out_valid = oval_p2;

endmodule

// File: tb/tb_mac_vec_pipe.sv
// Directed bench for mac_vec_pipe: default 24-bit instance plus a 16-bit accumulator instance for wrap/saturation.
module tb_mac_vec_pipe;

  logic clk;
  logic rst_n;
  logic Clr;
  int   n_checks;
  int   n_fail;

  mac_vec_pipe_if #(.DATA_WIDTH(8), .LANES(4), .ACC_WIDTH(24)) bus ();
  mac_vec_pipe_if #(.DATA_WIDTH(8), .LANES(4), .ACC_WIDTH(16)) bus16 ();

  mac_vec_pipe #(.DATA_WIDTH(8), .LANES(4), .ACC_WIDTH(24), .VEC_LEN(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .Clr(Clr), .bus(bus.slave));

  mac_vec_pipe #(.DATA_WIDTH(8), .LANES(4), .ACC_WIDTH(16), .VEC_LEN(4)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .Clr(Clr), .bus(bus16.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef MAC_SAT_EN
  localparam logic [63:0] EXP_U16   = {4{16'hFFFF}};
  localparam logic [63:0] EXP_SP16  = {4{16'h7FFF}};
  localparam logic [63:0] EXP_SN16  = {4{16'h8000}};
  localparam logic        EXP_OVF16 = 1'b1;
`else
  localparam logic [63:0] EXP_U16   = {4{16'hF804}};
  localparam logic [63:0] EXP_SP16  = {4{16'h0000}};
  localparam logic [63:0] EXP_SN16  = {4{16'h0200}};
  localparam logic        EXP_OVF16 = 1'b0;
`endif

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send_vec(input logic [31:0] a, input logic [31:0] b, input logic s);
    bus.Ain = a; bus.Bin = b; bus.Signed = s; bus.in_valid = 1'b1;
    repeat (4) cyc();
    bus.in_valid = 1'b0;
  endtask

  task automatic send16(input logic [31:0] a, input logic [31:0] b, input logic s);
    bus16.Ain = a; bus16.Bin = b; bus16.Signed = s; bus16.in_valid = 1'b1;
    repeat (4) cyc();
    bus16.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) cyc();
    rst_n = 1'b1;
    #1;
    n_checks++; if (bus.Cout !== 96'd0) begin n_fail++; $display("FAIL reset_cout: got %h expected 0", bus.Cout); end
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
    n_checks++; if (bus.Ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b expected 0", bus.Ovf); end
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready); end
    cyc();
  endtask

  task automatic test_basic();
    bus.out_ready = 1'b1;
    send_vec({4{8'd2}}, {4{8'd3}}, 1'b0);
    n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL basic_flush_in_ready: got %b expected 0", bus.in_ready); end
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_flush_out_valid: got %b expected 0", bus.out_valid); end
    cyc();
    n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL basic_out_valid: got %b expected 1", bus.out_valid); end
    n_checks++; if (bus.Cout !== {4{24'd24}}) begin n_fail++; $display("FAIL basic_cout: got %h expected %h", bus.Cout, {4{24'd24}}); end
    n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL basic_hold_in_ready: got %b expected 0", bus.in_ready); end
    cyc();
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_after_hs_valid: got %b expected 0", bus.out_valid); end
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL basic_after_hs_ready: got %b expected 1", bus.in_ready); end
    n_checks++; if (bus.Cout !== {4{24'd24}}) begin n_fail++; $display("FAIL basic_cout_kept: got %h expected %h", bus.Cout, {4{24'd24}}); end
  endtask

  task automatic test_hold();
    bus.out_ready = 1'b0;
    send_vec({4{8'd2}}, {4{8'd3}}, 1'b0);
    cyc();
    bus.Ain = {4{8'd9}}; bus.Bin = {4{8'd9}}; bus.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL hold_valid[%0d]: got %b expected 1", i, bus.out_valid); end
      n_checks++; if (bus.Cout !== {4{24'd24}}) begin n_fail++; $display("FAIL hold_cout[%0d]: got %h expected %h", i, bus.Cout, {4{24'd24}}); end
      n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL hold_in_ready[%0d]: got %b expected 0", i, bus.in_ready); end
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    cyc();
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL hold_release_valid: got %b expected 0", bus.out_valid); end
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL hold_release_ready: got %b expected 1", bus.in_ready); end
    send_vec({4{8'd1}}, {4{8'd1}}, 1'b0);
    cyc();
    n_checks++; if (bus.Cout !== {4{24'd4}}) begin n_fail++; $display("FAIL hold_restart_cout: got %h expected %h", bus.Cout, {4{24'd4}}); end
    cyc();
  endtask

  task automatic test_reset_mid();
    bus.out_ready = 1'b1;
    send_vec({4{8'd2}}, {4{8'd3}}, 1'b0);
    cyc(); cyc();
    bus.Ain = {4{8'd5}}; bus.Bin = {4{8'd5}}; bus.in_valid = 1'b1;
    cyc(); cyc();
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    #2;
    n_checks++; if (bus.Cout !== 96'd0) begin n_fail++; $display("FAIL rstmid_cout: got %h expected 0", bus.Cout); end
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_out_valid: got %b expected 0", bus.out_valid); end
    n_checks++; if (bus.Ovf !== 1'b0) begin n_fail++; $display("FAIL rstmid_ovf: got %b expected 0", bus.Ovf); end
    #2;
    rst_n = 1'b1;
    cyc();
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_in_ready: got %b expected 1", bus.in_ready); end
    send_vec({4{8'd1}}, {4{8'd1}}, 1'b0);
    cyc();
    n_checks++; if (bus.Cout !== {4{24'd4}}) begin n_fail++; $display("FAIL rstmid_fresh_cout: got %h expected %h", bus.Cout, {4{24'd4}}); end
    cyc();
  endtask

  task automatic test_signed();
    bus.out_ready = 1'b1;
    send_vec({4{8'hFF}}, {4{8'h02}}, 1'b1);
    cyc();
    n_checks++; if (bus.Cout !== {4{24'hFFFFF8}}) begin n_fail++; $display("FAIL signed_cout: got %h expected %h", bus.Cout, {4{24'hFFFFF8}}); end
    cyc();
    send_vec({4{8'hFF}}, {4{8'h02}}, 1'b0);
    cyc();
    n_checks++; if (bus.Cout !== {4{24'h0007F8}}) begin n_fail++; $display("FAIL unsigned_cout: got %h expected %h", bus.Cout, {4{24'h0007F8}}); end
    cyc();
  endtask

  task automatic test_lanes();
    bus.out_ready = 1'b1;
    send_vec({8'd4, 8'd3, 8'd2, 8'd1}, {8'd8, 8'd7, 8'd6, 8'd5}, 1'b0);
    cyc();
    n_checks++; if (bus.Cout !== {24'd128, 24'd84, 24'd48, 24'd20}) begin n_fail++; $display("FAIL lanes_unsigned: got %h expected %h", bus.Cout, {24'd128, 24'd84, 24'd48, 24'd20}); end
    cyc();
    send_vec({8'hFE, 8'd3, 8'h80, 8'd127}, {8'd5, 8'hFD, 8'h80, 8'd127}, 1'b1);
    cyc();
    n_checks++; if (bus.Cout !== {24'hFFFFD8, 24'hFFFFDC, 24'h010000, 24'h00FC04}) begin n_fail++; $display("FAIL lanes_signed: got %h expected %h", bus.Cout, {24'hFFFFD8, 24'hFFFFDC, 24'h010000, 24'h00FC04}); end
    cyc();
  endtask

  task automatic test_clr();
    bus.out_ready = 1'b1;
    bus.Ain = {4{8'd2}}; bus.Bin = {4{8'd3}}; bus.Signed = 1'b0; bus.in_valid = 1'b1;
    cyc(); cyc();
    Clr = 1'b1;
    #1;
    n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL clr_in_ready: got %b expected 0", bus.in_ready); end
    cyc();
    Clr = 1'b0;
    bus.in_valid = 1'b0;
    send_vec({4{8'd2}}, {4{8'd3}}, 1'b0);
    cyc();
    n_checks++; if (bus.Cout !== {4{24'd24}}) begin n_fail++; $display("FAIL clr_fresh_cout: got %h expected %h", bus.Cout, {4{24'd24}}); end
    cyc();
    for (int j = 0; j < 4; j++) begin
      bus.in_valid = 1'b1;
      cyc();
      bus.in_valid = 1'b0;
      cyc();
      if (j == 2) begin
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL gap_early_valid: got %b expected 0", bus.out_valid); end
      end
    end
    n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL gap_out_valid: got %b expected 1", bus.out_valid); end
    n_checks++; if (bus.Cout !== {4{24'd24}}) begin n_fail++; $display("FAIL gap_cout: got %h expected %h", bus.Cout, {4{24'd24}}); end
    cyc();
    bus.out_ready = 1'b0;
    send_vec({4{8'd2}}, {4{8'd3}}, 1'b0);
    cyc();
    Clr = 1'b1;
    bus.out_ready = 1'b1;
    cyc();
    Clr = 1'b0;
    #1;
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL clr_hs_valid: got %b expected 0", bus.out_valid); end
    n_checks++; if (bus.Cout !== 96'd0) begin n_fail++; $display("FAIL clr_hs_cout: got %h expected 0", bus.Cout); end
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL clr_hs_in_ready: got %b expected 1", bus.in_ready); end
    cyc();
  endtask

  task automatic test_sat();
    bus16.out_ready = 1'b0;
    send16({4{8'hFF}}, {4{8'hFF}}, 1'b0);
    cyc();
    n_checks++; if (bus16.Cout !== EXP_U16) begin n_fail++; $display("FAIL sat_u_cout: got %h expected %h", bus16.Cout, EXP_U16); end
    n_checks++; if (bus16.Ovf !== EXP_OVF16) begin n_fail++; $display("FAIL sat_u_ovf: got %b expected %b", bus16.Ovf, EXP_OVF16); end
    cyc();
    n_checks++; if (bus16.Ovf !== EXP_OVF16) begin n_fail++; $display("FAIL sat_u_ovf_held: got %b expected %b", bus16.Ovf, EXP_OVF16); end
    bus16.out_ready = 1'b1;
    cyc();
    n_checks++; if (bus16.Ovf !== 1'b0) begin n_fail++; $display("FAIL sat_ovf_cleared: got %b expected 0", bus16.Ovf); end
    send16({4{8'h80}}, {4{8'h80}}, 1'b1);
    cyc();
    n_checks++; if (bus16.Cout !== EXP_SP16) begin n_fail++; $display("FAIL sat_sp_cout: got %h expected %h", bus16.Cout, EXP_SP16); end
    n_checks++; if (bus16.Ovf !== EXP_OVF16) begin n_fail++; $display("FAIL sat_sp_ovf: got %b expected %b", bus16.Ovf, EXP_OVF16); end
    cyc();
    send16({4{8'h80}}, {4{8'h7F}}, 1'b1);
    cyc();
    n_checks++; if (bus16.Cout !== EXP_SN16) begin n_fail++; $display("FAIL sat_sn_cout: got %h expected %h", bus16.Cout, EXP_SN16); end
    cyc();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    Clr = 1'b0;
    bus.in_valid = 1'b0; bus.Signed = 1'b0; bus.Ain = '0; bus.Bin = '0; bus.out_ready = 1'b1;
    bus16.in_valid = 1'b0; bus16.Signed = 1'b0; bus16.Ain = '0; bus16.Bin = '0; bus16.out_ready = 1'b1;
    test_reset();
    test_basic();
    test_hold();
    test_reset_mid();
    test_signed();
    test_lanes();
    test_clr();
    test_sat();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
